debug_uart_rx: RTL and testbench

//  Receive side of the calibration debug link: host-to-board UART receiver plus frame parser.

---
 rtl/debug_uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_debug_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_rx.sv
// Calibration debug link receiver: 8N1 UART deserialiser plus 0xBE 0xEF frame parser
// that emits one coefficient write strobe per frame whose XOR checksum matches.
module debug_uart_rx #(
    parameter int unsigned DIV    = 12,
    parameter logic [7:0]  MAGIC1 = 8'hBE,
    parameter logic [7:0]  MAGIC2 = 8'hEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        err_o,
    output logic [7:0]  err_count
);

    localparam int unsigned   CW        = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;

    localparam logic [2:0] P_M1   = 3'd0;
    localparam logic [2:0] P_M2   = 3'd1;
    localparam logic [2:0] P_ADDR = 3'd2;
    localparam logic [2:0] P_DHI  = 3'd3;
    localparam logic [2:0] P_DLO  = 3'd4;
    localparam logic [2:0] P_CHK  = 3'd5;

    logic          rx_m;
    logic          rx_s;
    logic [2:0]    bit_state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          byte_stb;
    logic          cnt_done;
    logic          frame_err;

    logic [2:0]    p_state;
    logic [7:0]    addr_q;
    logic [7:0]    dhi_q;
    logic [7:0]    dlo_q;
    logic          chk_ok;
    logic          err_evt;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // update from the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
        end
    end

    assign cnt_done  = (bit_cnt == '0);
    assign frame_err = (bit_state == S_STOP) && cnt_done && !rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_state <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            byte_stb  <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            case (bit_state)
                S_IDLE: begin
                    if (!rx_s) begin
                        bit_state <= S_START;
                        bit_cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (!cnt_done) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (!rx_s) begin
                        bit_state <= S_DATA;
                        bit_cnt   <= FULL_LOAD;
                        bit_idx   <= 3'd0;
                    end else begin
                        bit_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!cnt_done) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        shift[bit_idx] <= rx_s;
                        bit_cnt        <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
                            bit_state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (!cnt_done) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (rx_s) begin
                        byte_stb  <= 1'b1;
                        bit_state <= S_IDLE;
                    end else begin
                        bit_state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (rx_s) begin
                        bit_state <= S_IDLE;
                    end
                end
                default: bit_state <= S_IDLE;
            endcase
        end
    end

    // shift stays stable for many cycles after byte_stb, so the parser reads it directly.
    assign chk_ok  = (shift == (addr_q ^ dhi_q ^ dlo_q));
    assign err_evt = frame_err || (byte_stb && (p_state == P_CHK) && !chk_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state   <= P_M1;
            addr_q    <= 8'h00;
            dhi_q     <= 8'h00;
            dlo_q     <= 8'h00;
            wr_valid  <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 16'h0000;
            err_o     <= 1'b0;
            err_count <= 8'h00;
        end else begin
            wr_valid <= 1'b0;
            err_o    <= err_evt;
            if (err_evt && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (frame_err) begin
                p_state <= P_M1;
            end else if (byte_stb) begin
                case (p_state)
                    P_M1: begin
                        if (shift == MAGIC1) p_state <= P_M2;
                    end
                    P_M2: begin
                        if (shift == MAGIC2)      p_state <= P_ADDR;
                        else if (shift != MAGIC1) p_state <= P_M1;
                    end
                    P_ADDR: begin
                        addr_q  <= shift;
                        p_state <= P_DHI;
                    end
                    P_DHI: begin
                        dhi_q   <= shift;
                        p_state <= P_DLO;
                    end
                    P_DLO: begin
                        dlo_q   <= shift;
                        p_state <= P_CHK;
                    end
                    P_CHK: begin
                        if (chk_ok) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= addr_q;
                            wr_data  <= {dhi_q, dlo_q};
                        end
                        p_state <= P_M1;
                    end
                    default: p_state <= P_M1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_uart_rx.sv
// Bench for debug_uart_rx: serialises byte streams onto rx_i and compares the observed
// writes and error activity with a byte-stream scanning model of the frame protocol.
`timescale 1ns/1ps
module tb_debug_uart_rx;

    localparam int DIV = 12;
    localparam logic [7:0] M1 = 8'hBE;
    localparam logic [7:0] M2 = 8'hEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_i;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        err_o;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  stream[$];
    logic [23:0] exp_wr[$];
    logic [23:0] got_wr[$];
    int closed_err  = 0;
    int err_pulses  = 0;
    int err_consec  = 0;
    int hold_viol   = 0;
    logic        prev_err = 1'b0;
    logic [23:0] prev_out = 24'h0;

    debug_uart_rx #(.DIV(DIV), .MAGIC1(M1), .MAGIC2(M2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err_o     (err_o),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) got_wr.push_back({wr_addr, wr_data});
            if (err_o) err_pulses++;
            if (err_o && prev_err) err_consec++;
            if (!wr_valid && ({wr_addr, wr_data} != prev_out)) hold_viol++;
        end
        prev_err = err_o;
        prev_out = {wr_addr, wr_data};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scan the bytes received since the last parser reset and list the writes a
    // conforming receiver performs; returns the number of checksum failures.
    task automatic scan_stream(output int n_bad);
        int i;
        int j;
        logic [7:0] a, h, l, c;
        exp_wr.delete();
        n_bad = 0;
        i = 0;
        while (i < stream.size()) begin
            if (stream[i] != M1) begin
                i++;
                continue;
            end
            j = i + 1;
            while (j < stream.size() && stream[j] == M1) j++;
            if (j >= stream.size()) break;
            if (stream[j] != M2) begin
                i = j + 1;
                continue;
            end
            if (j + 4 >= stream.size()) break;
            a = stream[j+1];
            h = stream[j+2];
            l = stream[j+3];
            c = stream[j+4];
            if ((a ^ h ^ l) == c) exp_wr.push_back({a, h, l});
            else n_bad++;
            i = j + 5;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_low);
        rx_i = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_i = b[k];
            repeat (DIV) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx_i = 1'b0;
            repeat (stop_low * DIV) @(negedge clk);
        end
        rx_i = 1'b1;
        repeat (DIV) @(negedge clk);
        if (stop_low == 0) stream.push_back(b);
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 0);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input bit bad);
        logic [7:0] c;
        c = a ^ d[15:8] ^ d[7:0];
        if (bad) c = c ^ 8'h5A;
        send_byte(M1, 0);
        send_byte(M2, 0);
        send_byte(a, 0);
        send_byte(d[15:8], 0);
        send_byte(d[7:0], 0);
        send_byte(c, 0);
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic verify(input string tag);
        int n;
        int tot;
        repeat (3 * DIV) @(negedge clk);
        scan_stream(n);
        tot = closed_err + n;
        check({tag, "_nwr"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check({tag, "_wr"}, got_wr[i], exp_wr[i]);
        check({tag, "_errpulse"}, err_pulses, tot);
        check({tag, "_errcnt"}, err_count, sat(tot));
        check({tag, "_hold"}, hold_viol, 0);
        check({tag, "_consec"}, err_consec, 0);
    endtask

    // A framing error sends the parser back to hunting, so the model starts a fresh stream.
    task automatic framing_byte(input logic [7:0] b, input int stop_low);
        int n;
        scan_stream(n);
        send_byte(b, stop_low);
        closed_err += n + 1;
        stream.delete();
        got_wr.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        stream.delete();
        got_wr.delete();
        closed_err = 0;
        err_pulses = 0;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] seq[$];
        int n;
        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_valid", wr_valid, 0);
        check("rst_err", err_o, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_errcnt", err_count, 0);
        rst = 1'b0;
        repeat (DIV) @(negedge clk);

        send_frame(8'h03, 16'h1234, 1'b0);
        verify("good");
        check("good_addr", wr_addr, 8'h03);
        check("good_data", wr_data, 16'h1234);

        seq = '{M1, M2, 8'h03, 8'h12, 8'h34, 8'h00};
        send_seq(seq);
        verify("badchk");
        check("badchk_addr", wr_addr, 8'h03);
        check("badchk_data", wr_data, 16'h1234);
        check("badchk_cnt", err_count, 8'd1);

        seq = '{8'h55, M1, M1, M2, 8'h07, 8'hAB, 8'hCD, 8'h61};
        send_seq(seq);
        verify("resync");
        check("resync_addr", wr_addr, 8'h07);
        check("resync_data", wr_data, 16'hABCD);

        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        verify("glitch");

        framing_byte(8'hA5, 2);
        verify("frmerr");
        check("frmerr_cnt", err_count, 8'd2);
        send_frame(8'h42, 16'hBEEF, 1'b0);
        verify("after_frm");

        seq = '{M1, M2, 8'h03};
        send_seq(seq);
        do_reset(3);
        check("mid_rst_addr", wr_addr, 0);
        check("mid_rst_data", wr_data, 0);
        check("mid_rst_cnt", err_count, 0);
        check("mid_rst_valid", wr_valid, 0);
        seq = '{M1, M2, 8'h01, 8'h00, 8'h02, 8'h03};
        send_seq(seq);
        verify("post_rst");
        check("post_rst_addr", wr_addr, 8'h01);
        check("post_rst_data", wr_data, 16'h0002);

        for (int f = 0; f < 16; f++) begin
            int junk;
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) send_byte(8'($urandom), 0);
            repeat ($urandom_range(0, DIV)) @(negedge clk);
            send_frame(8'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
        end
        verify("random");

        for (int f = 0; f < 8; f++) send_frame(8'($urandom), 16'($urandom), 1'b1);
        verify("sat_chk");
        scan_stream(n);
        while (closed_err + n < 255) begin
            framing_byte(8'h3C, 1);
            n = 0;
        end
        verify("sat_255");
        for (int f = 0; f < 6; f++) framing_byte(8'h3C, 1);
        send_frame(8'h10, 16'h0BAD, 1'b1);
        verify("sat_hold");
        send_frame(8'h11, 16'hC0DE, 1'b0);
        verify("sat_write");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
